// File: rtl/vga_crtc.sv
// vga_crtc - CRT timing controller for the VGA text display.
//
// Divides the system clock into a pixel enable, sweeps the horizontal (h) and
// vertical (v) position counters, and produces sync, blanking, coordinate and
// character-cell outputs. Every output is registered, and coordinates and decode
// change only on an edge where en_o=1, so a consumer that samples with en_o sees
// all of them aligned.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   en_o         pixel enable, one-cycle pulse every CLK_DIV clocks
//   hsync_o      horizontal sync, active level HSYNC_POL
//   vsync_o      vertical sync, active level VSYNC_POL
//   video_on_o   high inside the visible area
//   pixel_x_o    horizontal position h
//   pixel_y_o    vertical position v
//   char_col_o   pixel_x_o[9:3]  (80 columns of 8-pixel glyphs)
//   glyph_col_o  pixel_x_o[2:0]
//   char_row_o   pixel_y_o[8:4]  (30 rows of 16-line glyphs)
//   glyph_row_o  pixel_y_o[3:0]
//   line_o       one-cycle pulse after the counters move to h=0
//   frame_o      one-cycle pulse after the counters move to (0,0)
module vga_crtc #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       en_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o,
  output logic [6:0] char_col_o,
  output logic [2:0] glyph_col_o,
  output logic [4:0] char_row_o,
  output logic [3:0] glyph_row_o,
  output logic       line_o,
  output logic       frame_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] P_MAX  = PW'(CLK_DIV - 1);
  localparam logic [9:0]    H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [PW-1:0] p_q, p_d;
  logic          en_q, en_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          vid_q, vid_d, hs_q, hs_d, vs_q, vs_d;
  logic          line_q, line_d, frame_q, frame_d;

  always_comb begin
    p_d     = (p_q == P_MAX) ? '0 : p_q + 1'b1;
    // en is a registered copy of the terminal prescaler count, so the first
    // pulse appears after edge CLK_DIV (and from edge 1 when CLK_DIV=1).
    en_d    = (p_q == P_MAX);
    h_d     = h_q;
    v_d     = v_q;
    vid_d   = vid_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (en_q) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Decode from the next-state position so the flags land on the same
      // edge as the coordinates they describe.
      vid_d   = (h_d < H_VIS) && (v_d < V_VIS);
      hs_d    = (h_d >= HS_BEG && h_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vs_d    = (v_d >= VS_BEG && v_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      line_d  = (h_d == '0);
      frame_d = (h_d == '0) && (v_d == '0);
    end
  end

  // Counters reset to the last position so the first enable wraps to (0,0)
  // and the very first frame starts with line_o/frame_o like every other.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      p_q     <= '0;
      en_q    <= 1'b0;
      h_q     <= H_MAX;
      v_q     <= V_MAX;
      vid_q   <= 1'b0;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      en_q    <= en_d;
      h_q     <= h_d;
      v_q     <= v_d;
      vid_q   <= vid_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign en_o        = en_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;
  assign video_on_o  = vid_q;
  assign pixel_x_o   = h_q;
  assign pixel_y_o   = v_q;
  assign char_col_o  = h_q[9:3];
  assign glyph_col_o = h_q[2:0];
  assign char_row_o  = v_q[8:4];
  assign glyph_row_o = v_q[3:0];
  assign line_o      = line_q;
  assign frame_o     = frame_q;

endmodule

// File: doc/vga_crtc.md
# vga_crtc

CRT controller for the v65C02 VGA text display. Divides the system clock into a pixel enable, sweeps horizontal and vertical position counters, and generates `hsync`, `vsync`, `video_on`, pixel coordinates and character-cell addresses. These signals are the upstream source of the Synchronizer's `en_i`, `hsync_i`, `vsync_i` and `video_on_i` inputs, and of the video RAM / character ROM address path.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (≥1).
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BACK`, 48: horizontal back porch.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BACK`, 33: vertical back porch.
- `HSYNC_POL`, 0: active level of `hsync_o`.
- `VSYNC_POL`, 0: active level of `vsync_o`.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `en_o`  out  1  pixel enable; one-cycle pulse every `CLK_DIV` clocks.
- `hsync_o`  out  1  horizontal sync.
- `vsync_o`  out  1  vertical sync.
- `video_on_o`  out  1  high inside the visible area.
- `pixel_x_o`  out  10  horizontal position h.
- `pixel_y_o`  out  10  vertical position v.
- `char_col_o`  out  7  `pixel_x_o[9:3]`.
- `glyph_col_o`  out  3  `pixel_x_o[2:0]`.
- `char_row_o`  out  5  `pixel_y_o[8:4]`.
- `glyph_row_o`  out  4  `pixel_y_o[3:0]`.
- `line_o`  out  1  one-cycle pulse at the start of each line.
- `frame_o`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Prescaler p counts 0..CLK_DIV-1 and wraps. `en_o` is registered as (p == CLK_DIV-1).
- Position counters:
  - h advances on every edge where `en_o`=1, wrapping H_TOTAL-1 → 0.
  - v increments only when h wraps, wrapping V_TOTAL-1 → 0.
  - `pixel_x_o`/`pixel_y_o` are the h/v registers themselves.
- Decode, registered on the same edge as the counter update so all outputs stay aligned:
  - `video_on_o` = (h < H_DISPLAY) && (v < V_DISPLAY).
  - `hsync_o` = HSYNC_POL when H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC (656..751); otherwise ~HSYNC_POL.
  - `vsync_o` = VSYNC_POL when V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC (490..491); otherwise ~VSYNC_POL.
  - `line_o` = 1 for the single cycle after the update to h=0.
  - `frame_o` = 1 for the single cycle after the update to (0,0).
- Character-cell outputs are pure slices of the coordinates, for an 80×30 grid of 8×16 glyphs.

## Timing
- Reset values:
  - p=0, `en_o`=0.
  - h=H_TOTAL-1 (799), v=V_TOTAL-1 (524).
  - `video_on_o`=0, `hsync_o`=~HSYNC_POL, `vsync_o`=~VSYNC_POL.
  - `line_o`=0, `frame_o`=0.
- Startup: the first `en_o` edge after reset moves the counters to (0,0), so every frame, including the first, starts cleanly.
- After `rst_ni` is released, `en_o` is first high after edge CLK_DIV, then every CLK_DIV clocks, exactly one cycle wide. CLK_DIV=1 gives `en_o` constantly high from edge 1.
- Coordinates and decode change only on the edge where `en_o`=1, then hold for CLK_DIV cycles. Downstream consumers sample them with the same `en_o`.
- Rollover: a line wrap and a frame wrap on the same edge (h=799, v=524 → 0,0) asserts both `line_o` and `frame_o` in the same cycle.
- Reset mid-operation: any edge with `rst_ni`=0 forces all reset values on that edge, regardless of p, h or v. Restart is identical to power-up.
- Counter arithmetic is unsigned. h and v never exceed H_TOTAL-1 and V_TOTAL-1.

## Test plan
- Reset release (defaults):
  - During reset: x=799, y=524, `en_o`=0, `hsync_o`=`vsync_o`=1, `video_on_o`=0.
  - `en_o` goes high after edge 4.
  - After edge 5: x=0, y=0, `video_on_o`=1, `frame_o`=`line_o`=1 for one cycle.
- Enable cadence: `en_o` pulses are exactly 1 cycle wide with a period of 4 clocks over 1000 pulses.
- Horizontal:
  - `hsync_o`=0 exactly for x 656..751 (384 clocks).
  - `video_on_o`=1 for x 0..639 on y<480.
  - `line_o` period 3200 clocks.
  - `char_col_o`=79 at x=639.
- Vertical:
  - `vsync_o`=0 exactly for y 490..491 (6400 clocks).
  - `video_on_o`=0 for all y ≥ 480.
  - `frame_o` period 1,680,000 clocks.
  - `char_row_o`=29, `glyph_row_o`=15 at y=479.
- Mid-frame reset: pull `rst_ni` low for one edge at x=300, y=100. On that edge, outputs return to reset values, and the restart sequence matches the reset-release scenario.
- Parameter override: with HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1:
  - `hsync_o`=1 only for x 656..751.
  - `vsync_o`=1 only for y 490..491.
  - `en_o` stays high every cycle after edge 1.
